// File: rtl/intr_controller_pkg.sv
// Shared definitions for the interrupt controller: register word offsets, FSM encoding, cause width.
// Pure declarations; no latency or flow control.
package intr_controller_pkg;

  localparam int CAUSE_W = 5;

  localparam logic [1:0] OFF_PEND = 2'd0;
  localparam logic [1:0] OFF_MASK = 2'd1;
  localparam logic [1:0] OFF_ISR  = 2'd2;
  localparam logic [1:0] OFF_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } intc_state_e;

  function automatic logic in_window(input logic [27:0] addr_hi, input logic [27:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/intr_controller_if.sv
// CPU data-bus view of the controller's 16-byte register window (aluout/data/wmem side).
// Reads are combinational; writes take effect on the next clock edge, never stalled.
interface intr_controller_if;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;
  logic        bus_hit;

  modport master (
    output bus_addr, bus_wdata, bus_we,
    input  bus_rdata, bus_hit
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we,
    output bus_rdata, bus_hit
  );

endinterface

// File: rtl/intr_controller_prio_enc.sv
// Lowest-set-index priority encoder (bit 0 wins) plus any-set flag.
// Purely combinational, zero latency, no backpressure.
module intr_controller_prio_enc
  import intr_controller_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]       vec_i,
  output logic [CAUSE_W-1:0] idx_o,
  output logic               any_o
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = CAUSE_W'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/intr_controller.sv
// Memory-mapped interrupt controller: edge-detected pending bits, mask, fixed priority, Intr/Inta claim, EOI.
// irq rise to Intr is two edges; register reads are combinational, writes land on the next edge.
module intr_controller
  import intr_controller_pkg::*;
#(
  parameter int          NSRC      = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_FF00
) (
  input  logic                Clk,
  input  logic                Clrn,
  input  logic [NSRC-1:0]     irq_in,
  input  logic                Inta,
  intr_controller_if.slave    bus,
  output logic                Intr,
  output logic [CAUSE_W-1:0]  cause_id
);

  logic [NSRC-1:0]    pend_q, pend_d;
  logic [NSRC-1:0]    mask_q, mask_d;
  logic [NSRC-1:0]    irq_prev_q;
  intc_state_e        state_q;
  logic               intr_q;
  logic [CAUSE_W-1:0] cause_q;

  logic [NSRC-1:0]    rise, active, win_1h, clr;
  logic [CAUSE_W-1:0] win_idx;
  logic               win_any;
  logic               hit, wr_pend, wr_mask, wr_eoi, claim, in_service;
  logic               unused_bits;

  assign hit        = in_window(bus.bus_addr[31:4], BASE_ADDR[31:4]);
  assign wr_pend    = hit && bus.bus_we && (bus.bus_addr[3:2] == OFF_PEND);
  assign wr_mask    = hit && bus.bus_we && (bus.bus_addr[3:2] == OFF_MASK);
  assign wr_eoi     = hit && bus.bus_we && (bus.bus_addr[3:2] == OFF_EOI);
  assign in_service = (state_q == ST_SERV);
  assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata, BASE_ADDR[3:0]};

  assign rise   = irq_in & ~irq_prev_q;
  assign active = pend_q & mask_q;

  intr_controller_prio_enc #(.N(NSRC)) u_prio (
    .vec_i (active),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Claim and W1C both use pre-update PEND/MASK; a new rise in the same cycle wins over either clear.
  assign claim  = (state_q == ST_REQ) && Inta;
  assign win_1h = win_any ? (NSRC'(1) << win_idx) : '0;
  assign clr    = (wr_pend ? bus.bus_wdata[NSRC-1:0] : '0) | (claim ? win_1h : '0);
  assign pend_d = rise | (pend_q & ~clr);
  assign mask_d = wr_mask ? bus.bus_wdata[NSRC-1:0] : mask_q;

  always_comb begin
    bus.bus_rdata = '0;
    if (hit) begin
      case (bus.bus_addr[3:2])
        OFF_PEND: bus.bus_rdata = 32'(pend_q);
        OFF_MASK: bus.bus_rdata = 32'(mask_q);
        OFF_ISR:  bus.bus_rdata = 32'({in_service, cause_q});
        default:  bus.bus_rdata = '0;
      endcase
    end
  end

  assign bus.bus_hit = hit;
  assign Intr        = intr_q;
  assign cause_id    = cause_q;

  always_ff @(posedge Clk) begin
    if (Clrn) begin
      pend_q     <= '0;
      mask_q     <= '0;
      irq_prev_q <= '0;
      state_q    <= ST_IDLE;
      intr_q     <= 1'b0;
      cause_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      irq_prev_q <= irq_in;
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            state_q <= ST_REQ;
            intr_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (Inta) begin
            state_q <= ST_SERV;
            cause_q <= win_idx;
            intr_q  <= 1'b0;
          end else if (!win_any) begin
            state_q <= ST_IDLE;
            intr_q  <= 1'b0;
          end
        end
        ST_SERV: begin
          if (wr_eoi) state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
// Directed self-checking bench for intr_controller: reset, claim, priority, withdraw, masking, corner cases.
module tb_intr_controller;

  localparam logic [31:0] A_PEND = 32'h0000_FF00;
  localparam logic [31:0] A_MASK = 32'h0000_FF04;
  localparam logic [31:0] A_ISR  = 32'h0000_FF08;
  localparam logic [31:0] A_EOI  = 32'h0000_FF0C;

  logic       Clk = 1'b0;
  logic       Clrn;
  logic       Inta;
  logic [7:0] irq_in;
  logic       Intr;
  logic [4:0] cause_id;
  logic [31:0] rv;
  int n_cmp = 0;
  int n_err = 0;

  intr_controller_if bus_if ();

  intr_controller #(.NSRC(8), .BASE_ADDR(32'h0000_FF00)) dut (
    .Clk      (Clk),
    .Clrn     (Clrn),
    .irq_in   (irq_in),
    .Inta     (Inta),
    .bus      (bus_if),
    .Intr     (Intr),
    .cause_id (cause_id)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_we    = 1'b1;
    tick();
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = 32'h0;
    bus_if.bus_wdata = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.bus_addr = a;
    #1;
    d = bus_if.bus_rdata;
    bus_if.bus_addr = 32'h0;
  endtask

  task automatic pulse_inta();
    Inta = 1'b1;
    tick();
    Inta = 1'b0;
  endtask

  task automatic test_reset();
    Clrn = 1'b1; Inta = 1'b0; irq_in = 8'hFF;
    bus_if.bus_addr = 32'h0; bus_if.bus_wdata = 32'h0; bus_if.bus_we = 1'b0;
    tick(); tick();
    n_cmp++; if (Intr !== 1'b0) begin n_err++; $display("FAIL reset_intr got %b exp 0", Intr); end
    n_cmp++; if (cause_id !== 5'd0) begin n_err++; $display("FAIL reset_cause got %0d exp 0", cause_id); end
    rd(A_PEND, rv);
    n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL reset_pend got %h exp 0", rv); end
    rd(A_MASK, rv);
    n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL reset_mask got %h exp 0", rv); end
    bus_if.bus_addr = A_ISR; #1;
    n_cmp++; if (bus_if.bus_hit !== 1'b1) begin n_err++; $display("FAIL hit_in_window got %b exp 1", bus_if.bus_hit); end
    bus_if.bus_addr = 32'h0000_FF10; #1;
    n_cmp++; if (bus_if.bus_hit !== 1'b0 || bus_if.bus_rdata !== 32'h0) begin
      n_err++; $display("FAIL hit_out_window got hit=%b rdata=%h exp hit=0 rdata=0", bus_if.bus_hit, bus_if.bus_rdata);
    end
    bus_if.bus_addr = 32'h0;
    irq_in = 8'h00; Clrn = 1'b0;
    tick();
    n_cmp++; if (Intr !== 1'b0) begin n_err++; $display("FAIL reset_release_intr got %b exp 0", Intr); end
  endtask

  task automatic test_basic();
    wr(A_MASK, 32'h04);
    irq_in = 8'h04;
    tick();
    rd(A_PEND, rv);
    n_cmp++; if (rv !== 32'h04) begin n_err++; $display("FAIL basic_pend_set got %h exp 04", rv); end
    n_cmp++; if (Intr !== 1'b0) begin n_err++; $display("FAIL basic_intr_early got %b exp 0", Intr); end
    irq_in = 8'h00;
    tick();
    n_cmp++; if (Intr !== 1'b1) begin n_err++; $display("FAIL basic_intr_k2 got %b exp 1", Intr); end
    pulse_inta();
    n_cmp++; if (cause_id !== 5'd2) begin n_err++; $display("FAIL basic_cause got %0d exp 2", cause_id); end
    n_cmp++; if (Intr !== 1'b0) begin n_err++; $display("FAIL basic_intr_claimed got %b exp 0", Intr); end
    rd(A_PEND, rv);
    n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL basic_pend_claimed got %h exp 0", rv); end
    rd(A_ISR, rv);
    n_cmp++; if (rv !== 32'h22) begin n_err++; $display("FAIL basic_isr got %h exp 22", rv); end
    rd(A_EOI, rv);
    n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL basic_eoi_read got %h exp 0", rv); end
    wr(A_EOI, 32'h0);
    rd(A_ISR, rv);
    n_cmp++; if (rv !== 32'h02) begin n_err++; $display("FAIL basic_isr_after_eoi got %h exp 02", rv); end
    tick();
    n_cmp++; if (Intr !== 1'b0) begin n_err++; $display("FAIL basic_intr_after_eoi got %b exp 0", Intr); end
  endtask

  task automatic test_priority();
    wr(A_MASK, 32'hFF);
    irq_in = 8'h28;
    tick();
    irq_in = 8'h00;
    tick();
    n_cmp++; if (Intr !== 1'b1) begin n_err++; $display("FAIL prio_intr got %b exp 1", Intr); end
    pulse_inta();
    n_cmp++; if (cause_id !== 5'd3) begin n_err++; $display("FAIL prio_cause_first got %0d exp 3", cause_id); end
    rd(A_PEND, rv);
    n_cmp++; if (rv !== 32'h20) begin n_err++; $display("FAIL prio_pend_left got %h exp 20", rv); end
    wr(A_EOI, 32'h1);
    n_cmp++; if (Intr !== 1'b0) begin n_err++; $display("FAIL prio_intr_eoi_edge got %b exp 0", Intr); end
    tick();
    n_cmp++; if (Intr !== 1'b1) begin n_err++; $display("FAIL prio_intr_reassert got %b exp 1", Intr); end
    pulse_inta();
    n_cmp++; if (cause_id !== 5'd5) begin n_err++; $display("FAIL prio_cause_second got %0d exp 5", cause_id); end
    rd(A_PEND, rv);
    n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL prio_pend_empty got %h exp 0", rv); end
    wr(A_EOI, 32'h0);
  endtask

  task automatic test_withdraw();
    wr(A_MASK, 32'h01);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    n_cmp++; if (Intr !== 1'b1) begin n_err++; $display("FAIL wd_intr got %b exp 1", Intr); end
    wr(A_PEND, 32'h01);
    rd(A_PEND, rv);
    n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL wd_pend_cleared got %h exp 0", rv); end
    tick();
    n_cmp++; if (Intr !== 1'b0) begin n_err++; $display("FAIL wd_intr_dropped got %b exp 0", Intr); end
    rd(A_ISR, rv);
    n_cmp++; if (rv !== 32'h05) begin n_err++; $display("FAIL wd_isr_idle got %h exp 05", rv); end
    pulse_inta();
    n_cmp++; if (cause_id !== 5'd5) begin n_err++; $display("FAIL wd_inta_idle_ignored got %0d exp 5", cause_id); end
  endtask

  task automatic test_masked();
    wr(A_MASK, 32'h00);
    irq_in = 8'h80;
    tick();
    irq_in = 8'h00;
    tick();
    rd(A_PEND, rv);
    n_cmp++; if (rv !== 32'h80) begin n_err++; $display("FAIL mask_pend got %h exp 80", rv); end
    tick();
    n_cmp++; if (Intr !== 1'b0) begin n_err++; $display("FAIL mask_intr_blocked got %b exp 0", Intr); end
    wr(A_MASK, 32'hFFFF_FF80);
    rd(A_MASK, rv);
    n_cmp++; if (rv !== 32'h80) begin n_err++; $display("FAIL mask_upper_bits got %h exp 80", rv); end
    n_cmp++; if (Intr !== 1'b0) begin n_err++; $display("FAIL mask_intr_write_edge got %b exp 0", Intr); end
    tick();
    n_cmp++; if (Intr !== 1'b1) begin n_err++; $display("FAIL mask_intr_enabled got %b exp 1", Intr); end
    pulse_inta();
    n_cmp++; if (cause_id !== 5'd7) begin n_err++; $display("FAIL mask_cause got %0d exp 7", cause_id); end
    wr(A_EOI, 32'h0);
  endtask

  task automatic test_corner();
    wr(A_MASK, 32'h02);
    irq_in = 8'h02;
    tick();
    irq_in = 8'h00;
    tick();
    n_cmp++; if (Intr !== 1'b1) begin n_err++; $display("FAIL corner_intr got %b exp 1", Intr); end
    irq_in = 8'h02;
    pulse_inta();
    n_cmp++; if (cause_id !== 5'd1) begin n_err++; $display("FAIL corner_cause got %0d exp 1", cause_id); end
    rd(A_PEND, rv);
    n_cmp++; if (rv !== 32'h02) begin n_err++; $display("FAIL corner_rerise_pend got %h exp 02", rv); end
    pulse_inta();
    rd(A_ISR, rv);
    n_cmp++; if (rv !== 32'h21) begin n_err++; $display("FAIL corner_inta_serv_isr got %h exp 21", rv); end
    rd(A_PEND, rv);
    n_cmp++; if (rv !== 32'h02) begin n_err++; $display("FAIL corner_inta_serv_pend got %h exp 02", rv); end
    n_cmp++; if (Intr !== 1'b0) begin n_err++; $display("FAIL corner_serv_intr got %b exp 0", Intr); end
    Clrn = 1'b1;
    tick();
    irq_in = 8'h00;
    Clrn = 1'b0;
    tick();
    rd(A_ISR, rv);
    n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL corner_reset_isr got %h exp 0", rv); end
    rd(A_PEND, rv);
    n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL corner_reset_pend got %h exp 0", rv); end
    rd(A_MASK, rv);
    n_cmp++; if (rv !== 32'h0) begin n_err++; $display("FAIL corner_reset_mask got %h exp 0", rv); end
    n_cmp++; if (Intr !== 1'b0 || cause_id !== 5'd0) begin
      n_err++; $display("FAIL corner_reset_outputs got intr=%b cause=%0d exp intr=0 cause=0", Intr, cause_id);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_withdraw();
    test_masked();
    test_corner();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
